// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-slot vending controller.
// Holds the FSM state encoding, alarm codes and the change denomination table.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_CHANGE,
    ST_ALARM
  } state_t;

  localparam logic [1:0] ALM_NONE     = 2'b00;
  localparam logic [1:0] ALM_SOLD_OUT = 2'b01;
  localparam logic [1:0] ALM_FUNDS    = 2'b10;
  localparam logic [1:0] ALM_TIMEOUT  = 2'b11;

  // Largest first; denominations wider than the money path are never used.
  localparam int DENOM_NUM = 5;
  localparam int DENOM_TABLE [DENOM_NUM] = '{100, 50, 10, 5, 1};

  function automatic bit denom_fits(input int denom, input int val_w);
    return (val_w >= 31) || (denom <= ((1 << val_w) - 1));
  endfunction

endpackage

// File: rtl/vending_change_gen.sv
// Greedy change dispenser: presents one coin at a time from the remaining credit
// and holds it stable until the downstream handshake accepts it.
module vending_change_gen
  import vending_pkg::*;
#(
  parameter int VAL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic [VAL_W-1:0] credit,
  input  logic             chg_ready,
  output logic             chg_valid,
  output logic [VAL_W-1:0] chg_coin,
  output logic             chg_accept
);

  logic             chg_valid_reg;
  logic [VAL_W-1:0] chg_coin_reg;
  logic [VAL_W-1:0] remain_after;

  function automatic logic [VAL_W-1:0] pick_coin(input logic [VAL_W-1:0] amt);
    logic [VAL_W-1:0] coin;
    coin = '0;
    // Walk smallest to largest so the last fitting match is the largest one.
    for (int k = DENOM_NUM - 1; k >= 0; k--) begin
      if (denom_fits(DENOM_TABLE[k], VAL_W) && (VAL_W'(DENOM_TABLE[k]) <= amt))
        coin = VAL_W'(DENOM_TABLE[k]);
    end
    return coin;
  endfunction

  assign chg_accept   = chg_valid_reg && chg_ready;
  assign remain_after = credit - (chg_accept ? chg_coin_reg : '0);

  always_ff @(posedge clk) begin
    if (rst || !active) begin
      chg_valid_reg <= 1'b0;
      chg_coin_reg  <= '0;
    end else if (!chg_valid_reg || chg_ready) begin
      if (remain_after != '0) begin
        chg_valid_reg <= 1'b1;
        chg_coin_reg  <= pick_coin(remain_after);
      end else begin
        chg_valid_reg <= 1'b0;
        chg_coin_reg  <= '0;
      end
    end
  end

  assign chg_valid = chg_valid_reg;
  assign chg_coin  = chg_coin_reg;

endmodule

// File: rtl/vending_multi_controller.sv
// Multi-product vending controller: credit accumulation, purchase/alarm FSM,
// per-slot price/stock storage, sales total and greedy change return.
module vending_multi_controller
  import vending_pkg::*;
#(
  parameter int NUM_PROD    = 4,
  parameter int VAL_W       = 8,
  parameter int STOCK_W     = 4,
  parameter int SALES_W     = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coin_valid,
  input  logic [VAL_W-1:0]            coin_value,
  input  logic                        sel_valid,
  input  logic [$clog2(NUM_PROD)-1:0] sel_id,
  input  logic                        cancel,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_PROD)-1:0] cfg_id,
  input  logic [VAL_W-1:0]            cfg_price,
  input  logic [STOCK_W-1:0]          cfg_qty,
  output logic                        vend_valid,
  output logic [$clog2(NUM_PROD)-1:0] vend_id,
  input  logic                        vend_ready,
  output logic                        chg_valid,
  output logic [VAL_W-1:0]            chg_coin,
  input  logic                        chg_ready,
  output logic [VAL_W-1:0]            credit,
  output logic [SALES_W-1:0]          total_sales,
  output logic [NUM_PROD-1:0]         sold_out,
  output logic                        alarm,
  output logic [1:0]                  alarm_code,
  output logic                        coin_reject,
  output logic                        busy
);

  localparam int ID_W  = $clog2(NUM_PROD);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W:0]    NUM_PROD_W = (ID_W + 1)'(NUM_PROD);

  state_t               state_reg, state_next;
  logic [VAL_W-1:0]     credit_reg, credit_next;
  logic [SALES_W-1:0]   sales_reg, sales_next;
  logic [ID_W-1:0]      vend_id_reg, vend_id_next;
  logic [1:0]           alarm_code_reg, alarm_code_next;
  logic                 coin_reject_reg, coin_reject_next;
  logic [TMR_W-1:0]     timer_reg;
  logic                 buy_en;

  logic [VAL_W-1:0]     price_arr [NUM_PROD];
  logic [STOCK_W-1:0]   stock_arr [NUM_PROD];

  logic                 coin_open, coin_add;
  logic [VAL_W:0]       coin_sum;
  logic [VAL_W-1:0]     credit_eff;
  logic                 sel_in_range, sel_empty;
  logic [VAL_W-1:0]     sel_price;
  logic                 cfg_en;
  logic                 chg_accept;

  assign coin_open  = (state_reg == ST_IDLE) || (state_reg == ST_CREDIT);
  assign coin_sum   = {1'b0, credit_reg} + {1'b0, coin_value};
  assign coin_add   = coin_open && coin_valid && (coin_value != '0) && !coin_sum[VAL_W];
  assign credit_eff = coin_add ? coin_sum[VAL_W-1:0] : credit_reg;

  // Out-of-range slot ids behave as permanently sold out.
  assign sel_in_range = ({1'b0, sel_id} < NUM_PROD_W);
  assign sel_price    = sel_in_range ? price_arr[sel_id] : '0;
  assign sel_empty    = !sel_in_range || (stock_arr[sel_id] == '0);
  assign cfg_en       = cfg_we && (state_reg == ST_IDLE);

  generate
    for (genvar gi = 0; gi < NUM_PROD; gi++) begin : gen_slot
      logic [VAL_W-1:0]   price_reg;
      logic [STOCK_W-1:0] stock_reg;
      logic [STOCK_W:0]   qty_sum;

      assign qty_sum = {1'b0, stock_reg} + {1'b0, cfg_qty};

      always_ff @(posedge clk) begin
        if (rst) begin
          price_reg <= '0;
          stock_reg <= '0;
        end else if (cfg_en && (cfg_id == ID_W'(gi))) begin
          price_reg <= cfg_price;
          stock_reg <= qty_sum[STOCK_W] ? '1 : qty_sum[STOCK_W-1:0];
        end else if (buy_en && (sel_id == ID_W'(gi))) begin
          stock_reg <= stock_reg - 1'b1;
        end
      end

      assign price_arr[gi] = price_reg;
      assign stock_arr[gi] = stock_reg;
      assign sold_out[gi]  = (stock_reg == '0);
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    sales_next       = sales_reg;
    vend_id_next     = vend_id_reg;
    alarm_code_next  = ALM_NONE;
    coin_reject_next = coin_valid && (!coin_open || coin_sum[VAL_W]);
    buy_en           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        credit_next = credit_eff;
        if (sel_valid) begin
          state_next      = ST_ALARM;
          alarm_code_next = ALM_FUNDS;
        end else if (coin_add) begin
          state_next = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        credit_next = credit_eff;
        if (cancel) begin
          state_next = ST_CHANGE;
        end else if (sel_valid) begin
          // Purchase is judged against credit including any same-cycle coin.
          if (sel_empty) begin
            state_next      = ST_ALARM;
            alarm_code_next = ALM_SOLD_OUT;
          end else if (credit_eff < sel_price) begin
            state_next      = ST_ALARM;
            alarm_code_next = ALM_FUNDS;
          end else begin
            credit_next  = credit_eff - sel_price;
            sales_next   = sales_reg + SALES_W'(sel_price);
            vend_id_next = sel_id;
            buy_en       = 1'b1;
            state_next   = ST_VEND;
          end
        end else if (!coin_valid && (timer_reg == TMR_LAST)) begin
          state_next      = ST_CHANGE;
          alarm_code_next = ALM_TIMEOUT;
        end
      end
      ST_VEND: begin
        if (vend_ready)
          state_next = (credit_reg != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        credit_next = credit_reg - (chg_accept ? chg_coin : '0);
        if (credit_next == '0)
          state_next = ST_IDLE;
      end
      ST_ALARM: begin
        state_next = (credit_reg != '0) ? ST_CREDIT : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      credit_reg      <= '0;
      sales_reg       <= '0;
      vend_id_reg     <= '0;
      alarm_code_reg  <= ALM_NONE;
      coin_reject_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      sales_reg       <= sales_next;
      vend_id_reg     <= vend_id_next;
      alarm_code_reg  <= alarm_code_next;
      coin_reject_reg <= coin_reject_next;
    end
  end

  // Idle timer restarts on entry to CREDIT and whenever a coin shows up.
  always_ff @(posedge clk) begin
    if (rst || (state_reg != ST_CREDIT) || coin_valid)
      timer_reg <= '0;
    else
      timer_reg <= timer_reg + 1'b1;
  end

  vending_change_gen #(
    .VAL_W(VAL_W)
  ) u_change_gen (
    .clk       (clk),
    .rst       (rst),
    .active    (state_reg == ST_CHANGE),
    .credit    (credit_reg),
    .chg_ready (chg_ready),
    .chg_valid (chg_valid),
    .chg_coin  (chg_coin),
    .chg_accept(chg_accept)
  );

  assign vend_valid  = (state_reg == ST_VEND);
  assign vend_id     = vend_id_reg;
  assign credit      = credit_reg;
  assign total_sales = sales_reg;
  assign alarm       = (state_reg == ST_ALARM);
  assign alarm_code  = alarm_code_reg;
  assign coin_reject = coin_reject_reg;
  assign busy        = (state_reg == ST_VEND) || (state_reg == ST_CHANGE);

endmodule

// File: tb/tb_vending_multi_controller.sv
// Scoreboard bench: stimulus queues expected vend/change/alarm/reject events,
// a negedge monitor pops and compares them as the controller emits them.
module tb_vending_multi_controller;

  localparam int NUM_PROD    = 4;
  localparam int VAL_W       = 8;
  localparam int STOCK_W     = 4;
  localparam int SALES_W     = 16;
  localparam int TIMEOUT_CYC = 16;
  localparam int ID_W        = 2;

  localparam int EV_VEND  = 1;
  localparam int EV_CHG   = 2;
  localparam int EV_ALARM = 3;
  localparam int EV_TMO   = 4;
  localparam int EV_REJ   = 5;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                coin_valid = 1'b0;
  logic [VAL_W-1:0]    coin_value = '0;
  logic                sel_valid = 1'b0;
  logic [ID_W-1:0]     sel_id = '0;
  logic                cancel = 1'b0;
  logic                cfg_we = 1'b0;
  logic [ID_W-1:0]     cfg_id = '0;
  logic [VAL_W-1:0]    cfg_price = '0;
  logic [STOCK_W-1:0]  cfg_qty = '0;
  logic                vend_ready = 1'b0;
  logic                chg_ready = 1'b0;
  logic                vend_valid;
  logic [ID_W-1:0]     vend_id;
  logic                chg_valid;
  logic [VAL_W-1:0]    chg_coin;
  logic [VAL_W-1:0]    credit;
  logic [SALES_W-1:0]  total_sales;
  logic [NUM_PROD-1:0] sold_out;
  logic                alarm;
  logic [1:0]          alarm_code;
  logic                coin_reject;
  logic                busy;

  int  total = 0;
  int  bad = 0;
  ev_t exp_q[$];

  vending_multi_controller #(
    .NUM_PROD(NUM_PROD), .VAL_W(VAL_W), .STOCK_W(STOCK_W),
    .SALES_W(SALES_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_price(cfg_price), .cfg_qty(cfg_qty),
    .vend_valid(vend_valid), .vend_id(vend_id), .vend_ready(vend_ready),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
    .credit(credit), .total_sales(total_sales), .sold_out(sold_out),
    .alarm(alarm), .alarm_code(alarm_code), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_val", val, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int id, input int price, input int qty);
    cfg_we = 1'b1; cfg_id = ID_W'(id); cfg_price = VAL_W'(price); cfg_qty = STOCK_W'(qty);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_coin(input int v);
    coin_valid = 1'b1; coin_value = VAL_W'(v);
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic do_sel(input int id);
    sel_valid = 1'b1; sel_id = ID_W'(id);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic wait_not_busy(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  // Monitor: one event per observed output transaction, plus hold checks on stalls.
  initial begin
    logic             prev_stall;
    logic [VAL_W-1:0] prev_coin;
    prev_stall = 1'b0;
    prev_coin  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("chg_hold_valid", chg_valid, 1);
          check("chg_hold_coin", chg_coin, prev_coin);
        end
        prev_stall = chg_valid && !chg_ready;
        prev_coin  = chg_coin;
        if (vend_valid && vend_ready) got_ev(EV_VEND, int'(vend_id));
        if (chg_valid && chg_ready)   got_ev(EV_CHG, int'(chg_coin));
        if (alarm)                    got_ev(EV_ALARM, int'(alarm_code));
        if (!alarm && alarm_code == 2'b11) got_ev(EV_TMO, 3);
        if (coin_reject)              got_ev(EV_REJ, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset values
    repeat (3) tick();
    check("rst_credit", credit, 0);
    check("rst_sales", total_sales, 0);
    check("rst_sold_out", sold_out, 4'b1111);
    check("rst_flags", {vend_valid, chg_valid, alarm, coin_reject, busy}, 0);
    check("rst_codes", {alarm_code, chg_coin, vend_id}, 0);
    rst = 1'b0;
    tick();

    // Price 35 in slot 1, pay 40, expect product then one 5 coin.
    do_cfg(1, 35, 2);
    check("cfg_sold_out", sold_out, 4'b1101);
    do_coin(20);
    check("credit_20", credit, 20);
    do_coin(20);
    check("credit_40", credit, 40);
    expect_ev(EV_VEND, 1);
    expect_ev(EV_CHG, 5);
    do_sel(1);
    check("buy_credit", credit, 5);
    check("buy_sales", total_sales, 35);
    check("buy_vend_valid", vend_valid, 1);
    check("buy_busy", busy, 1);
    chg_ready = 1'b1;
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    wait_not_busy("buy_done", 20);
    check("buy_end_credit", credit, 0);
    check("buy_end_sold_out", sold_out, 4'b1101);

    // Sold-out slot with credit: alarm 01, credit kept.
    do_coin(50);
    expect_ev(EV_ALARM, 1);
    do_sel(2);
    check("soldout_alarm", alarm, 1);
    check("soldout_code", alarm_code, 2'b01);
    check("soldout_credit", credit, 50);
    tick();
    check("soldout_alarm_clear", alarm, 0);
    check("soldout_credit_kept", credit, 50);

    // Credit 86, cancel with stalling acceptor.
    do_coin(36);
    check("credit_86", credit, 86);
    chg_ready = 1'b0;
    expect_ev(EV_CHG, 50);
    expect_ev(EV_CHG, 10);
    expect_ev(EV_CHG, 10);
    expect_ev(EV_CHG, 10);
    expect_ev(EV_CHG, 5);
    expect_ev(EV_CHG, 1);
    do_cancel();
    check("cancel_busy", busy, 1);
    n = 0;
    while (busy && n < 100) begin
      chg_ready = !chg_ready;
      tick();
      n++;
    end
    check("refund_done", busy, 0);
    check("refund_credit", credit, 0);
    chg_ready = 1'b1;

    // Insufficient funds, then coin+select in the same cycle.
    do_coin(10);
    expect_ev(EV_ALARM, 2);
    do_sel(1);
    tick();
    check("funds_credit", credit, 10);
    expect_ev(EV_VEND, 1);
    coin_valid = 1'b1; coin_value = 8'd25;
    sel_valid = 1'b1; sel_id = 2'd1;
    tick();
    coin_valid = 1'b0; sel_valid = 1'b0;
    check("combo_credit", credit, 0);
    check("combo_sales", total_sales, 70);
    check("combo_sold_out", sold_out, 4'b1111);
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    check("combo_idle", busy, 0);

    // Selection with no credit in IDLE.
    expect_ev(EV_ALARM, 2);
    do_sel(0);
    tick();
    check("idle_sel_credit", credit, 0);

    // Overflow rejection at credit 250.
    do_coin(100);
    do_coin(100);
    do_coin(50);
    check("credit_250", credit, 250);
    expect_ev(EV_REJ, 0);
    do_coin(10);
    check("overflow_credit", credit, 250);
    expect_ev(EV_CHG, 100);
    expect_ev(EV_CHG, 100);
    expect_ev(EV_CHG, 50);
    do_cancel();
    wait_not_busy("overflow_refund", 30);

    // Inactivity timeout refund.
    expect_ev(EV_TMO, 3);
    expect_ev(EV_CHG, 10);
    do_coin(10);
    n = 0;
    while (alarm_code != 2'b11 && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 16);
    check("timeout_no_alarm", alarm, 0);
    wait_not_busy("timeout_refund", 20);
    check("timeout_credit", credit, 0);

    // Reset while a change coin is stalled.
    do_coin(50);
    do_coin(30);
    chg_ready = 1'b0;
    do_cancel();
    tick();
    check("stall_valid", chg_valid, 1);
    check("stall_coin", chg_coin, 50);
    rst = 1'b1;
    tick();
    check("rst_chg_valid", chg_valid, 0);
    check("rst_mid_credit", credit, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sales", total_sales, 0);
    rst = 1'b0;
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_multi_controller.md
VENDING_MULTI_CONTROLLER -- requirements
Module: vending_multi_controller

Interface
REQ-001 SHALL have parameter NUM_PROD, default 4, number of product slots (2..16).
REQ-002 SHALL have parameter VAL_W, default 8, width of money values (credit, price, coin, change).
REQ-003 SHALL have parameter STOCK_W, default 4, width of per-slot stock counter.
REQ-004 SHALL have parameter SALES_W, default 16, width of total_sales accumulator.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1000, idle cycles in CREDIT before auto-refund.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports as follows: clk  in  1  clock, all logic on rising edge; rst  in  1  synchronous active-high reset.
REQ-007 Ports: coin_valid in 1 single-cycle coin strobe; coin_value in VAL_W coin amount.
REQ-008 Ports: sel_valid in 1 purchase request strobe; sel_id in $clog2(NUM_PROD) requested slot; cancel in 1 refund request strobe.
REQ-009 Ports: cfg_we in 1 price/restock write; cfg_id in $clog2(NUM_PROD) slot; cfg_price in VAL_W new price; cfg_qty in STOCK_W stock to add.
REQ-010 Ports: vend_valid out 1, vend_id out $clog2(NUM_PROD), vend_ready in 1 -- product dispense handshake.
REQ-011 Ports: chg_valid out 1, chg_coin out VAL_W, chg_ready in 1 -- one change coin per handshake.
REQ-012 Ports: credit out VAL_W; total_sales out SALES_W; sold_out out NUM_PROD, bit i = stock[i]==0; alarm out 1; alarm_code out 2; coin_reject out 1; busy out 1.

Function
REQ-013 SHALL implement states IDLE, CREDIT, VEND, CHANGE, ALARM; busy=1 in VEND and CHANGE.
REQ-014 IDLE/CREDIT: coin_valid with coin_value!=0 adds to credit next cycle and moves IDLE->CREDIT; each coin counted exactly once, no duplicate-value filtering.
REQ-015 Coin whose sum exceeds 2^VAL_W-1, or coin arriving in VEND/CHANGE/ALARM: credit unchanged, coin_reject pulses 1 cycle.
REQ-016 CREDIT, sel_valid: if stock[sel_id]==0 -> ALARM code 2'b01; else if credit<price[sel_id] -> ALARM code 2'b10; else credit-=price, stock-=1, total_sales+=price (wraps modulo 2^SALES_W), -> VEND, all next cycle.
REQ-017 sel_valid in IDLE (credit 0) SHALL go to ALARM code 2'b10.
REQ-018 VEND: vend_valid=1, vend_id stable until vend_ready sampled 1; then -> CHANGE if credit>0 else IDLE.
REQ-019 CHANGE: greedy denominations from package list (largest <= remaining credit); chg_coin stable while chg_valid && !chg_ready; each accepted coin subtracts from credit; credit==0 -> IDLE.
REQ-020 cancel in CREDIT SHALL go to CHANGE (full refund); cancel in other states ignored; sel_valid and cancel same cycle: cancel wins.
REQ-021 coin_valid and sel_valid same cycle in CREDIT: coin added first, purchase evaluated against the new credit.
REQ-022 Timeout counter clears on every coin and on entering CREDIT; reaching TIMEOUT_CYC -> CHANGE (auto-refund), alarm_code 2'b11 pulses 1 cycle without alarm.
REQ-023 ALARM: alarm=1 exactly 1 cycle period minimum; next cycle -> CREDIT if credit>0 else IDLE; alarm cleared on exit; credit retained.
REQ-024 cfg_we accepted only in IDLE: price[cfg_id]<=cfg_price, stock saturates at 2^STOCK_W-1 when adding cfg_qty; ignored elsewhere.
REQ-025 cfg_id or sel_id >= NUM_PROD SHALL be treated as sold-out (ALARM 2'b01) / ignored for cfg.

Reset
REQ-026 rst SHALL force state IDLE, credit 0, total_sales 0, all stock 0, all prices 0, timeout counter 0, vend_valid/chg_valid/alarm/coin_reject/busy 0, alarm_code 0, chg_coin 0, vend_id 0.
REQ-027 rst mid-VEND or mid-CHANGE SHALL abort the handshake and discard remaining credit in the same cycle; no output glitch beyond one cycle.

Structure
REQ-028 Package vending_pkg SHALL hold state enum, alarm code constants, and the denomination table (100,50,10,5,1 scaled to VAL_W).
REQ-029 Sub-module vending_change_gen SHALL implement greedy change selection and chg handshake; price/stock arrays stay in the top.

Verification
REQ-030 Reset; cfg slot1 price 35 qty 2; coins 20,20; sel 1; vend_ready -> vend_id 1, change coin 5, credit 0, total_sales 35, stock[1]=1.
REQ-031 Slot2 stock 0, credit 50, sel 2 -> alarm 1 cycle, alarm_code 01, credit stays 50, state CREDIT.
REQ-032 Credit 86, cancel, chg_ready toggling 1/0 -> coins 50,10,10,10,5,1 in order, each held while stalled, then IDLE.
REQ-033 VAL_W=8, credit 250, coin 10 -> coin_reject pulse, credit 250.
REQ-034 TIMEOUT_CYC=16, one coin 10, no activity -> after 16 cycles alarm_code 11 pulse, refund 10, IDLE.
REQ-035 Assert rst during CHANGE with chg_valid high -> next cycle chg_valid 0, credit 0, state IDLE.
